// File: rtl/excess3_result_display_if.sv
// Capture/display bundle between the Excess-3 adder side and the result display.
interface excess3_result_display_if;
  logic       load;
  logic       clr;
  logic [3:0] sum_x3;
  logic       cout;
  logic [6:0] seg;
  logic [1:0] an;
  logic       dig_err;
  logic       valid;

  modport master (output load, clr, sum_x3, cout, input seg, an, dig_err, valid);
  modport slave  (input load, clr, sum_x3, cout, output seg, an, dig_err, valid);
endinterface

// File: rtl/excess3_result_display.sv
// Latches an Excess-3 sum/carry and scans it onto a 2-digit active-low 7-segment display.
// Define ERR_BLINK_EN to blank the display during the upper half of each 64-frame period on errors.
module excess3_result_display #(
  parameter int REFRESH_W = 16
) (
  input logic                        clk,
  input logic                        rst_n,
  excess3_result_display_if.slave    bus
);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_ONE   = 7'b1111001;

  typedef enum logic [1:0] {IDLE, SCAN_U, SCAN_T} state_t;

  state_t               state_q, state_d;
  logic [REFRESH_W-1:0] cnt_q, cnt_d;
  logic [3:0]           sum_q, sum_d;
  logic                 cout_q, cout_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic [6:0]           seg_q, seg_d;
  logic [1:0]           an_q, an_d;
  logic                 tick;
  logic [6:0]           units_seg;
  logic [6:0]           tens_seg;
`ifdef ERR_BLINK_EN
  logic [5:0]           frame_q, frame_d;
`endif

  function automatic logic illegal_x3(input logic [3:0] code);
    return (code < 4'd3) || (code > 4'd12);
  endfunction

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_E;
    endcase
  endfunction

  assign tick      = &cnt_q;
  assign units_seg = err_q ? SEG_E : bcd_to_seg(sum_q - 4'd3);
  assign tens_seg  = cout_q ? SEG_ONE : SEG_BLANK;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = valid_q;
    err_d   = err_q;
    seg_d   = SEG_BLANK;
    an_d    = 2'b11;
`ifdef ERR_BLINK_EN
    frame_d = frame_q;
`endif

    // Scan sequencing; the counter naturally wraps to zero on tick.
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.load) state_d = SCAN_U;
      end
      SCAN_U: begin
        cnt_d = cnt_q + REFRESH_W'(1);
        an_d  = 2'b10;
        seg_d = units_seg;
        if (tick) state_d = SCAN_T;
      end
      SCAN_T: begin
        cnt_d = cnt_q + REFRESH_W'(1);
        an_d  = 2'b01;
        seg_d = tens_seg;
        if (tick) begin
          state_d = SCAN_U;
`ifdef ERR_BLINK_EN
          frame_d = frame_q + 6'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef ERR_BLINK_EN
    if (err_q && frame_q[5]) seg_d = SEG_BLANK;
`endif

    if (bus.load) begin
      sum_d   = bus.sum_x3;
      cout_d  = bus.cout;
      valid_d = 1'b1;
      err_d   = illegal_x3(bus.sum_x3);
    end

    // Clear wins over a coincident load.
    if (bus.clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      sum_d   = '0;
      cout_d  = 1'b0;
      valid_d = 1'b0;
      err_d   = 1'b0;
      seg_d   = SEG_BLANK;
      an_d    = 2'b11;
`ifdef ERR_BLINK_EN
      frame_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      seg_q   <= SEG_BLANK;
      an_q    <= 2'b11;
`ifdef ERR_BLINK_EN
      frame_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
`ifdef ERR_BLINK_EN
      frame_q <= frame_d;
`endif
    end
  end

  assign bus.seg     = seg_q;
  assign bus.an      = an_q;
  assign bus.dig_err = err_q;
  assign bus.valid   = valid_q;
endmodule

// File: tb/tb_excess3_result_display.sv
// Bench for excess3_result_display: directed table, async-reset sequence, and model-checked random traffic.
module tb_excess3_result_display;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] SE = 7'b0000110;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] SEGTAB [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                          7'b0000000, 7'b0010000};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   tot = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  excess3_result_display_if bus ();

  excess3_result_display #(.REFRESH_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       ld;
    logic       cl;
    logic [3:0] sum;
    logic       co;
    int         n;
    logic [1:0] an;
    logic [6:0] seg;
    logic       vld;
    logic       err;
  } vec_t;

  vec_t tbl [12];

  // Reference model: the display position is derived from the scan start edge by arithmetic.
  bit         m_scan;
  int         m_s;
  int         ecnt;
  logic [3:0] m_sum;
  logic       m_cout;
  logic       m_valid;
  logic       m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic cl, input logic [3:0] s, input logic co);
    bus.load   = ld;
    bus.clr    = cl;
    bus.sum_x3 = s;
    bus.cout   = co;
  endtask

  function automatic logic is_illegal(input logic [3:0] s);
    return (s < 4'd3) || (s > 4'd12);
  endfunction

  task automatic model_reset();
    m_scan  = 0;
    m_s     = 0;
    ecnt    = 0;
    m_sum   = '0;
    m_cout  = 1'b0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_edge(input logic ld, input logic cl, input logic [3:0] s, input logic co,
                            output logic [1:0] ean, output logic [6:0] eseg);
    int k;
    int ph;
    int fr;
    k = ecnt;
    ecnt = ecnt + 1;
    ean  = 2'b11;
    eseg = BL;
    if (m_scan) begin
      ph = ((k - m_s) / 4) % 2;
      fr = ((k - m_s) / 8) % 64;
      if (ph == 0) begin
        ean  = 2'b10;
        eseg = is_illegal(m_sum) ? SE : SEGTAB[m_sum - 4'd3];
      end else begin
        ean  = 2'b01;
        eseg = m_cout ? S1 : BL;
      end
`ifdef ERR_BLINK_EN
      if (m_err && fr >= 32) eseg = BL;
`else
      if (fr < 0) eseg = BL;
`endif
    end
    if (cl) begin
      ean     = 2'b11;
      eseg    = BL;
      m_scan  = 0;
      m_sum   = '0;
      m_cout  = 1'b0;
      m_valid = 1'b0;
      m_err   = 1'b0;
    end else if (ld) begin
      m_sum   = s;
      m_cout  = co;
      m_valid = 1'b1;
      m_err   = is_illegal(s);
      if (!m_scan) begin
        m_scan = 1;
        m_s    = ecnt;
      end
    end
  endtask

  task automatic mcycle(input logic ld, input logic cl, input logic [3:0] s, input logic co);
    logic [1:0] ean;
    logic [6:0] eseg;
    drive(ld, cl, s, co);
    step();
    model_edge(ld, cl, s, co, ean, eseg);
    chk("rnd_an", 32'(bus.an), 32'(ean));
    chk("rnd_seg", 32'(bus.seg), 32'(eseg));
    chk("rnd_valid", 32'(bus.valid), 32'(m_valid));
    chk("rnd_err", 32'(bus.dig_err), 32'(m_err));
    chk("rnd_an_not_00", 32'(bus.an == 2'b00), 32'd0);
    bus.load = 1'b0;
    bus.clr  = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 4'b1001, 1'b0, 1, 2'b11, BL, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 1, 2'b10, S6, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 4, 2'b01, BL, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 4, 2'b10, S6, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 4'b0100, 1'b1, 1, 2'b10, S6, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 1, 2'b10, S1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 2, 2'b01, S1, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 4'b1111, 1'b1, 1, 2'b01, S1, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 3, 2'b10, SE, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 4, 2'b01, S1, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 4'b0110, 1'b0, 1, 2'b11, BL, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 4'b0000, 1'b0, 3, 2'b11, BL, 1'b0, 1'b0};

    drive(1'b0, 1'b0, 4'b0000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_an", 32'(bus.an), 32'(2'b11));
    chk("rst_seg", 32'(bus.seg), 32'(BL));
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_err", 32'(bus.dig_err), 32'd0);
    repeat (3) step();
    chk("rst_hold_an", 32'(bus.an), 32'(2'b11));
    chk("rst_hold_seg", 32'(bus.seg), 32'(BL));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].ld, tbl[i].cl, tbl[i].sum, tbl[i].co);
      step();
      bus.load = 1'b0;
      bus.clr  = 1'b0;
      for (int j = 1; j < tbl[i].n; j++) step();
      chk($sformatf("tbl%0d_an", i), 32'(bus.an), 32'(tbl[i].an));
      chk($sformatf("tbl%0d_seg", i), 32'(bus.seg), 32'(tbl[i].seg));
      chk($sformatf("tbl%0d_valid", i), 32'(bus.valid), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_err", i), 32'(bus.dig_err), 32'(tbl[i].err));
    end

    // Asynchronous reset landing between edges while the tens digit is lit.
    drive(1'b1, 1'b0, 4'b0101, 1'b0);
    step();
    bus.load = 1'b0;
    repeat (5) step();
    chk("pre_arst_an", 32'(bus.an), 32'(2'b01));
    #3 rst_n = 1'b0;
    #1;
    chk("arst_an", 32'(bus.an), 32'(2'b11));
    chk("arst_seg", 32'(bus.seg), 32'(BL));
    chk("arst_valid", 32'(bus.valid), 32'd0);
    chk("arst_err", 32'(bus.dig_err), 32'd0);
    repeat (2) step();
    chk("arst_hold_an", 32'(bus.an), 32'(2'b11));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    chk("post_arst_idle_an", 32'(bus.an), 32'(2'b11));
    chk("post_arst_idle_seg", 32'(bus.seg), 32'(BL));
    chk("post_arst_valid", 32'(bus.valid), 32'd0);

    // Long error run so the frame counter passes 32 (blink window when enabled).
    model_reset();
    mcycle(1'b0, 1'b1, 4'b0000, 1'b0);
    mcycle(1'b1, 1'b0, 4'b1111, 1'b1);
    for (int i = 0; i < 300; i++) mcycle(1'b0, 1'b0, 4'($urandom), 1'($urandom));

    for (int i = 0; i < 2000; i++) begin
      mcycle(1'(($urandom % 8) == 0), 1'(($urandom % 256) == 0), 4'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
